// File: rtl/cpu_pkg.sv
// Shared definitions for the pipeline control slice.
package cpu_pkg;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    MEMW  = 2'd1,
    FLUSH = 2'd2
  } state_e;

  // Opcode the staging registers load when they insert a bubble or flush.
  localparam logic [3:0] NOP_OPC = 4'b1100;

  localparam int FLUSH_CYCLES_DEF = 2;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter used for the stall and flush performance counters.
module sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  output logic [CNT_W-1:0] q
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Increment on a qualifying cycle, stick at all-ones.
  always_comb begin
    cnt_d = cnt_q;
    if (inc && (cnt_q != '1)) cnt_d = cnt_q + 1'b1;
  end

  // Count register, cleared only by reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign q = cnt_q;

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline sequencing controller: memory freeze, load-use bubble and
// taken-branch flush for the 4-stage CPU, with saturating perf counters.
//
//   state | meaning
//   RUN   | normal issue; evaluates mem-stall > branch > load-use > normal
//   MEMW  | pipe frozen waiting for mem_ready
//   FLUSH | branch held high for the remaining fc cycles
import cpu_pkg::*;

module pipe_ctrl #(
  parameter int FLUSH_CYCLES = FLUSH_CYCLES_DEF,
  parameter int CNT_W        = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [3:0]       id_src0,
  input  logic             id_src0_vld,
  input  logic [3:0]       id_src1,
  input  logic             id_src1_vld,
  input  logic [3:0]       ex_dst,
  input  logic             ex_wrx,
  input  logic             ex_memrd,
  input  logic             mem_req,
  input  logic             mem_ready,
  input  logic             br_taken,
  output logic             pc_en,
  output logic             ifid_ld_en,
  output logic             idex_ld_en,
  output logic             hazard,
  output logic             branch,
  output logic             busy,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  localparam logic [2:0] FC_INIT = 3'(FLUSH_CYCLES - 1);

  state_e     state_q, state_d;
  logic [2:0] fc_q, fc_d;
  logic       lu, mem_stall, run_eval;

  assign lu = ex_memrd & ex_wrx &
              ((id_src0_vld & (id_src0 == ex_dst)) |
               (id_src1_vld & (id_src1 == ex_dst)));
  assign mem_stall = mem_req & ~mem_ready;

  // Next state and Mealy outputs; everything forced low while in reset.
  always_comb begin
    state_d    = state_q;
    fc_d       = fc_q;
    pc_en      = 1'b0;
    ifid_ld_en = 1'b0;
    idex_ld_en = 1'b0;
    hazard     = 1'b0;
    branch     = 1'b0;
    busy       = 1'b0;
    run_eval   = 1'b0;
    if (!rst) begin
      busy = (state_q != RUN);
      case (state_q)
        RUN: begin
          if (mem_stall) state_d = MEMW;
          else           run_eval = 1'b1;
        end
        MEMW: begin
          if (mem_ready) run_eval = 1'b1;
        end
        FLUSH: begin
          branch = 1'b1;
          if (!mem_stall) begin
            pc_en      = 1'b1;
            ifid_ld_en = 1'b1;
            idex_ld_en = 1'b1;
            if (fc_q <= 3'd1) begin
              state_d = RUN;
              fc_d    = 3'd0;
            end else begin
              fc_d = fc_q - 3'd1;
            end
          end
        end
        default: state_d = RUN;
      endcase
      // RUN decision, also used by MEMW in the cycle memory completes.
      if (run_eval) begin
        state_d = RUN;
        if (br_taken) begin
          pc_en      = 1'b1;
          ifid_ld_en = 1'b1;
          idex_ld_en = 1'b1;
          branch     = 1'b1;
          if (FLUSH_CYCLES > 1) begin
            state_d = FLUSH;
            fc_d    = FC_INIT;
          end
        end else if (lu) begin
          idex_ld_en = 1'b1;
          hazard     = 1'b1;
        end else begin
          pc_en      = 1'b1;
          ifid_ld_en = 1'b1;
          idex_ld_en = 1'b1;
        end
      end
    end
  end

  // State and flush-count registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= RUN;
      fc_q    <= 3'd0;
    end else begin
      state_q <= state_d;
      fc_q    <= fc_d;
    end
  end

  sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .clk (clk),
    .rst (rst),
    .inc (~pc_en),
    .q   (stall_cnt)
  );

  sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
    .clk (clk),
    .rst (rst),
    .inc (branch),
    .q   (flush_cnt)
  );

endmodule

// File: tb/tb_pipe_ctrl.sv
// Bench for pipe_ctrl: directed spec scenarios plus randomized traffic
// against a behavioural model of the pipe.
module tb_pipe_ctrl;

  localparam int FC   = 2;
  localparam int CW   = 16;
  localparam int MAXC = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst;
  logic [3:0]    id_src0, id_src1, ex_dst;
  logic          id_src0_vld, id_src1_vld, ex_wrx, ex_memrd;
  logic          mem_req, mem_ready, br_taken;
  logic          pc_en, ifid_ld_en, idex_ld_en, hazard, branch, busy;
  logic [CW-1:0] stall_cnt, flush_cnt;

  pipe_ctrl #(.FLUSH_CYCLES(FC), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst),
    .id_src0(id_src0), .id_src0_vld(id_src0_vld),
    .id_src1(id_src1), .id_src1_vld(id_src1_vld),
    .ex_dst(ex_dst), .ex_wrx(ex_wrx), .ex_memrd(ex_memrd),
    .mem_req(mem_req), .mem_ready(mem_ready), .br_taken(br_taken),
    .pc_en(pc_en), .ifid_ld_en(ifid_ld_en), .idex_ld_en(idex_ld_en),
    .hazard(hazard), .branch(branch), .busy(busy),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Stimulus vector: {src0[4], src0_vld, src1[4], src1_vld, dst[4], wrx, memrd, mreq, mrdy, br}
  localparam logic [18:0] NORM   = 19'd0;
  localparam logic [18:0] LU     = {4'd0, 1'b0, 4'd5, 1'b1, 4'd5, 1'b1, 1'b1, 3'b000};
  localparam logic [18:0] MSTALL = 19'b100;
  localparam logic [18:0] MREADY = 19'b110;
  localparam logic [18:0] BR     = 19'b001;

  // Model: is the pipe waiting on memory, how many more branch cycles are owed.
  bit         m_memw, m_memw_n;
  int         m_fleft, m_fleft_n;
  int         m_stall, m_flush;
  logic [5:0] m_exp;            // {pc, ifid, idex, hazard, branch, busy}

  wire [5:0]      obs     = {pc_en, ifid_ld_en, idex_ld_en, hazard, branch, busy};
  wire [6+2*CW-1:0] obs_all = {obs, stall_cnt, flush_cnt};
  logic [6+2*CW-1:0] exp_all;

  function automatic void apply(input logic [18:0] v);
    {id_src0, id_src0_vld, id_src1, id_src1_vld, ex_dst,
     ex_wrx, ex_memrd, mem_req, mem_ready, br_taken} = v;
  endfunction

  function automatic void model_reset();
    m_memw  = 1'b0;
    m_fleft = 0;
    m_stall = 0;
    m_flush = 0;
  endfunction

  function automatic void model_eval();
    bit en, haz, brn, half, stl, use_dep;
    en = 0; haz = 0; brn = 0; half = 0;
    stl = mem_req && !mem_ready;
    use_dep = ex_memrd && ex_wrx &&
              ((id_src0_vld && id_src0 == ex_dst) || (id_src1_vld && id_src1 == ex_dst));
    m_memw_n  = m_memw;
    m_fleft_n = m_fleft;
    if (m_fleft > 0) begin
      brn = 1;
      if (!stl) begin en = 1; m_fleft_n = m_fleft - 1; end
    end else if (m_memw && !mem_ready) begin
      // still frozen
    end else if (!m_memw && stl) begin
      m_memw_n = 1;
    end else begin
      m_memw_n = 0;
      if (br_taken) begin en = 1; brn = 1; m_fleft_n = FC - 1; end
      else if (use_dep) begin half = 1; haz = 1; end
      else en = 1;
    end
    m_exp   = {en, en, en | half, haz, brn, m_memw || (m_fleft > 0)};
    exp_all = {m_exp, m_stall[CW-1:0], m_flush[CW-1:0]};
  endfunction

  function automatic void model_commit();
    m_memw  = m_memw_n;
    m_fleft = m_fleft_n;
    if (!m_exp[5] && m_stall < MAXC) m_stall++;
    if (m_exp[1]  && m_flush < MAXC) m_flush++;
  endfunction

  task automatic test_reset();
    rst = 1'b1;
    apply(NORM);
    model_reset();
    #3;
    total++;
    if (obs_all !== '0) begin
      bad++; $display("FAIL reset_hold: got %h want 0", obs_all);
    end
    #19 rst = 1'b0;                // mid-cycle release
    @(posedge clk); #1;
    apply(NORM);
    @(negedge clk); model_eval();
    total++;
    if (obs !== 6'b111000 || obs_all !== exp_all) begin
      bad++; $display("FAIL reset_first_cycle: got %h want %h", obs_all, exp_all);
    end
    @(posedge clk); model_commit(); #1;
  endtask

  task automatic test_load_use();
    logic [18:0] stim [2] = '{LU, NORM};
    logic [5:0]  want [2] = '{6'b001100, 6'b111000};
    int s0 = m_stall;
    for (int i = 0; i < 2; i++) begin
      apply(stim[i]);
      @(negedge clk); model_eval();
      total++;
      if (obs !== want[i] || obs_all !== exp_all) begin
        bad++; $display("FAIL load_use[%0d]: got %h want %b / %h", i, obs_all, want[i], exp_all);
      end
      @(posedge clk); model_commit(); #1;
    end
    total++;
    if (int'(stall_cnt) !== s0 + 1) begin
      bad++; $display("FAIL load_use_cnt: got %0d want %0d", stall_cnt, s0 + 1);
    end
  endtask

  task automatic test_branch();
    logic [18:0] stim [3] = '{BR, NORM, NORM};
    logic [5:0]  want [3] = '{6'b111010, 6'b111011, 6'b111000};
    int f0 = m_flush;
    for (int i = 0; i < 3; i++) begin
      apply(stim[i]);
      @(negedge clk); model_eval();
      total++;
      if (obs !== want[i] || obs_all !== exp_all) begin
        bad++; $display("FAIL branch[%0d]: got %h want %b / %h", i, obs_all, want[i], exp_all);
      end
      @(posedge clk); model_commit(); #1;
    end
    total++;
    if (int'(flush_cnt) !== f0 + 2) begin
      bad++; $display("FAIL branch_cnt: got %0d want %0d", flush_cnt, f0 + 2);
    end
  endtask

  task automatic test_mem_wait();
    logic [18:0] stim [5] = '{MSTALL, MSTALL, MSTALL, MREADY, NORM};
    logic [5:0]  want [5] = '{6'b000000, 6'b000001, 6'b000001, 6'b111001, 6'b111000};
    int s0 = m_stall;
    for (int i = 0; i < 5; i++) begin
      apply(stim[i]);
      @(negedge clk); model_eval();
      total++;
      if (obs !== want[i] || obs_all !== exp_all) begin
        bad++; $display("FAIL mem_wait[%0d]: got %h want %b / %h", i, obs_all, want[i], exp_all);
      end
      @(posedge clk); model_commit(); #1;
    end
    total++;
    if (int'(stall_cnt) !== s0 + 3) begin
      bad++; $display("FAIL mem_wait_cnt: got %0d want %0d", stall_cnt, s0 + 3);
    end
  endtask

  task automatic test_simultaneous();
    logic [18:0] stim [11] = '{LU | BR, NORM, NORM, MSTALL | BR, MREADY | BR, NORM, NORM,
                               BR, MSTALL, MREADY, NORM};
    logic [5:0]  want [11] = '{6'b111010, 6'b111011, 6'b111000, 6'b000000, 6'b111011,
                               6'b111011, 6'b111000, 6'b111010, 6'b000011, 6'b111011,
                               6'b111000};
    for (int i = 0; i < 11; i++) begin
      apply(stim[i]);
      @(negedge clk); model_eval();
      total++;
      if (obs !== want[i] || obs_all !== exp_all) begin
        bad++; $display("FAIL simultaneous[%0d]: got %h want %b / %h", i, obs_all, want[i], exp_all);
      end
      @(posedge clk); model_commit(); #1;
    end
  endtask

  task automatic test_reset_mid_flush();
    apply(BR);
    @(posedge clk); #1;
    apply(NORM);
    #2;
    total++;
    if (obs !== 6'b111011) begin
      bad++; $display("FAIL flush_before_rst: got %b want 111011", obs);
    end
    rst = 1'b1;
    #1;
    total++;
    if (obs_all !== '0) begin
      bad++; $display("FAIL rst_mid_flush: got %h want 0", obs_all);
    end
    model_reset();
    @(posedge clk); #3 rst = 1'b0;
    @(posedge clk); #1;
    apply(NORM);
    @(negedge clk); model_eval();
    total++;
    if (obs !== 6'b111000 || obs_all !== exp_all) begin
      bad++; $display("FAIL after_rst: got %h want %h", obs_all, exp_all);
    end
    @(posedge clk); model_commit(); #1;
  endtask

  task automatic test_random();
    for (int i = 0; i < 3000; i++) begin
      id_src0     = 4'($urandom_range(0, 3));
      id_src1     = 4'($urandom_range(0, 3));
      ex_dst      = 4'($urandom_range(0, 3));
      id_src0_vld = 1'($urandom);
      id_src1_vld = 1'($urandom);
      ex_wrx      = 1'($urandom);
      ex_memrd    = 1'($urandom);
      mem_req     = ($urandom_range(0, 3) == 0);
      mem_ready   = 1'($urandom);
      br_taken    = ($urandom_range(0, 7) == 0);
      @(negedge clk); model_eval();
      total++;
      if (obs_all !== exp_all) begin
        bad++; $display("FAIL random[%0d]: got %h want %h", i, obs_all, exp_all);
      end
      @(posedge clk); model_commit(); #1;
    end
  endtask

  task automatic test_saturation();
    apply(MSTALL);
    for (int i = 0; i < 65540; i++) begin
      @(negedge clk); model_eval();
      @(posedge clk); model_commit(); #1;
    end
    @(negedge clk); model_eval();
    total++;
    if (stall_cnt !== 16'hFFFF || obs_all !== exp_all) begin
      bad++; $display("FAIL saturation: got %h want cnt ffff / %h", obs_all, exp_all);
    end
    @(posedge clk); model_commit(); #1;
    apply(MREADY);
    @(negedge clk); model_eval();
    total++;
    if (obs_all !== exp_all) begin
      bad++; $display("FAIL sat_release: got %h want %h", obs_all, exp_all);
    end
    @(posedge clk); model_commit(); #1;
  endtask

  initial begin
    test_reset();
    test_load_use();
    test_branch();
    test_mem_wait();
    test_simultaneous();
    test_reset_mid_flush();
    test_random();
    test_saturation();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pipe_ctrl.md
# pipe_ctrl

Pipeline sequencing controller for the 4-stage CPU. Generates the load enables for the PC and IF/ID registers, plus the load-enable, `hazard` and `branch` controls for the ID/EX staging register. It freezes the pipe on multi-cycle memory accesses, inserts one bubble on a load-use dependency, and flushes wrong-path instructions after a taken branch. It also keeps saturating stall and flush performance counters.

## Interface
Parameters:
- `FLUSH_CYCLES`, default 2: cycles `branch` stays asserted after a taken branch; legal range 1–7.
- `CNT_W`, default 16: performance counter width.

Ports:
- `clk`  in  1  system clock; all state updates on the rising edge.
- `rst`  in  1  reset, asynchronous and active-high.
- `id_src0`  in  4  decode-stage source register 0.
- `id_src0_vld`  in  1  decode-stage instruction reads `id_src0`.
- `id_src1`  in  4  decode-stage source register 1.
- `id_src1_vld`  in  1  decode-stage instruction reads `id_src1`.
- `ex_dst`  in  4  execute-stage destination register.
- `ex_wrx`  in  1  execute-stage instruction writes the register file.
- `ex_memrd`  in  1  execute-stage instruction is a load.
- `mem_req`  in  1  execute stage is issuing a memory read or write.
- `mem_ready`  in  1  memory completes the access this cycle.
- `br_taken`  in  1  execute stage resolved a taken branch.
- `pc_en`  out  1  PC load enable.
- `ifid_ld_en`  out  1  IF/ID register load enable.
- `idex_ld_en`  out  1  ID/EX staging register load enable.
- `hazard`  out  1  bubble request to the ID/EX staging register.
- `branch`  out  1  flush request to the ID/EX staging register.
- `busy`  out  1  controller is not in RUN.
- `stall_cnt`  out  CNT_W  count of cycles with `pc_en`=0.
- `flush_cnt`  out  CNT_W  count of cycles with `branch`=1.

## Operation
- The state register holds one of RUN, MEMW or FLUSH, plus a 3-bit flush counter `fc`. Outputs are Mealy: combinational from the state and the current inputs.
- Load-use hazard definition: `lu = ex_memrd & ex_wrx & ((id_src0_vld & id_src0==ex_dst) | (id_src1_vld & id_src1==ex_dst))`.
- Per-cycle priority is mem-stall > branch > load-use > normal.
- **RUN state:**
  - Mem-stall (`mem_req & !mem_ready`):
    - All three enables are 0; `hazard`=0 and `branch`=0.
    - Next state is MEMW.
  - Else, branch (`br_taken`):
    - `pc_en`=1, `ifid_ld_en`=1, `idex_ld_en`=1 and `branch`=1.
    - If FLUSH_CYCLES>1: next state is FLUSH and `fc` is set to FLUSH_CYCLES-1.
  - Else, load-use (`lu`):
    - `pc_en`=0, `ifid_ld_en`=0, `idex_ld_en`=1 and `hazard`=1.
    - State stays RUN. The inserted bubble clears `ex_memrd` on the next cycle, so the stall lasts exactly one cycle.
  - Else, normal: all enables 1, `hazard`=0 and `branch`=0.
- **MEMW state:**
  - While `mem_ready`=0: all enables 0; `hazard` and `branch` are 0.
  - When `mem_ready`=1: outputs are evaluated as in RUN with the mem-stall term ignored (so a branch or load-use in that cycle is honoured), and the next state follows the RUN rules.
- **FLUSH state:**
  - All enables 1 and `branch`=1; `br_taken` and `lu` are ignored; `fc` decrements each cycle.
  - Exit to RUN when `fc` reaches 1 on this cycle.
  - If `mem_req & !mem_ready` occurs in FLUSH: all enables are 0, `branch` is held at 1, and `fc` holds its value.
- `busy` = (state != RUN).
- Counters:
  - Each increments by 1 per qualifying cycle and saturates at 2^CNT_W-1; there is no wrap.
  - They are cleared only by `rst`.
- Register compare uses the full 4 bits. Register 0 is not special-cased.

## Timing
- Reset: while `rst`=1, state=RUN, `fc`=0, both counters 0, all enables 0, and `hazard`, `branch` and `busy` are 0.
- The first cycle after `rst` falls uses normal RUN output evaluation.
- Decision latency is 0 cycles: outputs respond combinationally in the same cycle as their inputs, and state updates on the next edge.
- Taken branch: `branch`=1 for exactly FLUSH_CYCLES consecutive cycles, extended by any interleaved mem-stall cycles.
- Memory handshake: the stall lasts exactly the number of cycles in which `mem_req`=1 and `mem_ready`=0. An access that completes (`mem_ready`=1) in the first cycle causes zero stall.
- Reset mid-FLUSH or mid-MEMW: the block returns to RUN immediately with no residual `branch`.

## Structure
- Shared package `cpu_pkg` holds:
  - the state enum (RUN=2'd0, MEMW=2'd1, FLUSH=2'd2);
  - the NOP opcode constant 4'b1100 used by the staging registers;
  - the default FLUSH_CYCLES.
- One sub-module, `sat_counter` (parameter CNT_W; ports `clk`, `rst`, `inc`, `q`), is instantiated twice, once for `stall_cnt` and once for `flush_cnt`.

## Test plan
- Load-use: `ex_memrd`=1, `ex_wrx`=1, `ex_dst`=5, `id_src1`=5, `id_src1_vld`=1 → one cycle with `hazard`=1, `pc_en`=0 and `idex_ld_en`=1; the next cycle is normal; `stall_cnt`=1.
- Branch: pulse `br_taken` for one cycle with FLUSH_CYCLES=2 → `branch`=1 for 2 cycles, enables remain 1, `flush_cnt`=2, `busy`=1 for 1 cycle.
- Memory wait: `mem_req`=1 with `mem_ready` low for 3 cycles, then high → enables 0 for 3 cycles and 1 in the 4th; `stall_cnt`=3.
- Simultaneous: `br_taken`=1 together with `lu`=1 → branch wins: `hazard`=0 and `branch`=1. Then `mem_req & !mem_ready` together with `br_taken` → freeze with `branch`=0; the branch is honoured in the `mem_ready` cycle.
- Reset mid-FLUSH: assert `rst` asynchronously during the first FLUSH cycle → all outputs 0 immediately, counters 0, state RUN after release.
- Saturation: hold a mem-stall for 65540 cycles with CNT_W=16 → `stall_cnt` stops at 65535.
